exponent_accelerator_key_in: RTL and testbench

- Avalon-MM slave input PIO for the board push-buttons (KEY[3:0], active-low); the read-direction counterpart to the HEX output PIOs.
- Data path: synchronises and debounces each input bit, then latches falling edges (key presses) into a write-1-to-clear edge-capture register.
- Raises a maskable level interrupt to the Nios II CPU. Sits on the system interconnect beside the HEX PIOs; software polls or takes the IRQ to start or acknowledge accelerator runs.

---
 rtl/exponent_accelerator_key_in_pkg.sv | 21 ++
 rtl/exponent_accelerator_debounce_bit.sv | 56 +++++
 rtl/exponent_accelerator_key_in.sv | 84 ++++++++
 tb/tb_exponent_accelerator_key_in.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/exponent_accelerator_key_in_pkg.sv
// Shared definitions for the push-button input PIO: register map, bus widths
// and the idle level of the active-low keys.
package exponent_accelerator_key_in_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  // Keys are active-low, so a released key idles at 1.
  localparam logic KEY_RELEASED = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } avmm_wr_t;

endpackage

// File: rtl/exponent_accelerator_debounce_bit.sv
// One key input: two-flop synchroniser, stability counter, accepted level and
// a same-edge pulse flagging an accepted 1->0 transition.
module exponent_accelerator_debounce_bit
  import exponent_accelerator_key_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic stable_o,
  output logic fall_c_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= KEY_RELEASED;
      sync2_q  <= KEY_RELEASED;
      stable_q <= KEY_RELEASED;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any disagreement must persist for DEBOUNCE_CYCLES edges; agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;
  assign fall_c_o = stable_q & ~stable_d;

endmodule

// File: rtl/exponent_accelerator_key_in.sv
// Avalon-MM input PIO for the board keys: debounced DATA, IRQMASK and a
// write-1-to-clear falling-edge capture register driving a level interrupt.
module exponent_accelerator_key_in
  import exponent_accelerator_key_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [REG_W-1:0]  writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [REG_W-1:0]  readdata,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  avmm_wr_t         wr_c;
  logic             wr_en_c;
  logic             unused_wd_c;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_key
    exponent_accelerator_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (in_port[i]),
      .stable_o(stable[i]),
      .fall_c_o(fall[i])
    );
  end

  assign wr_c        = '{addr: address, data: writedata};
  assign wr_en_c     = chipselect & ~write_n;
  assign unused_wd_c = ^wr_c.data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // A capture on the same edge as a W1C of that bit wins.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en_c && (wr_c.addr == ADDR_IRQMASK)) begin
      irqmask_d = wr_c.data[WIDTH-1:0];
    end
    if (wr_en_c && (wr_c.addr == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~wr_c.data[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | fall;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_RSVD:    readdata = '0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_exponent_accelerator_key_in.sv
// Directed bench for the key-input PIO with a small expected-value queue.
module tb_exponent_accelerator_key_in;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 8;
  localparam int unsigned CW    = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] exp_q[$];

  exponent_accelerator_key_in #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    exp_q.push_back(exp);
    #1;
    check(tag, readdata);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    exp_q.push_back({31'd0, exp});
    #1;
    check(tag, {31'd0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = '0;
    in_port     = 4'hF;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // reset values
    rd(2'd0, 32'h0000000F, "rst_data");
    rd(2'd1, 32'h0, "rst_rsvd");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_edgecap");
    chk_irq(1'b0, "rst_irq");
    wr(2'd1, 32'hFFFFFFFF);
    wr(2'd0, 32'h0);
    rd(2'd1, 32'h0, "rsvd_write_ignored");
    rd(2'd0, 32'h0000000F, "data_write_ignored");
    wr(2'd2, 32'hFFFFFFF0);
    rd(2'd2, 32'h0, "mask_upper_bits");

    // clean press of bit0: accepted exactly 2+DC cycles after the change
    in_port = 4'hE;
    tick(9);
    rd(2'd0, 32'hF, "press_data_early");
    rd(2'd3, 32'h0, "press_cap_early");
    tick(1);
    rd(2'd0, 32'hE, "press_data");
    rd(2'd3, 32'h1, "press_cap");
    chk_irq(1'b0, "press_irq_masked");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "cap_cleared");

    // glitch on bit1 rejected
    in_port = 4'hC;
    tick(5);
    in_port = 4'hE;
    tick(12);
    rd(2'd0, 32'hE, "glitch_data");
    rd(2'd3, 32'h0, "glitch_cap");
    // bounce then a held press
    in_port = 4'hC;
    tick(6);
    in_port = 4'hE;
    tick(1);
    in_port = 4'hC;
    tick(9);
    rd(2'd0, 32'hE, "bounce_data_early");
    rd(2'd3, 32'h0, "bounce_cap_early");
    tick(1);
    rd(2'd0, 32'hC, "bounce_data");
    rd(2'd3, 32'h2, "bounce_cap");
    tick(12);
    rd(2'd3, 32'h2, "bounce_cap_once");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "bounce_cap_cleared");

    // interrupt path on bit0; a release first must not capture
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1, "mask_write");
    in_port = 4'hD;
    tick(12);
    rd(2'd0, 32'hD, "release_data");
    rd(2'd3, 32'h0, "release_no_cap");
    chk_irq(1'b0, "release_irq");
    in_port = 4'hC;
    tick(9);
    chk_irq(1'b0, "irq_before_capture");
    tick(1);
    rd(2'd3, 32'h1, "irq_cap");
    chk_irq(1'b1, "irq_rise");
    wr(2'd3, 32'h2);
    chk_irq(1'b1, "irq_other_clear");
    wr(2'd3, 32'h1);
    chk_irq(1'b0, "irq_cleared");
    rd(2'd3, 32'h0, "irq_cap_cleared");

    // W1C of bit2 on the very edge bit2 is captured: set wins
    in_port = 4'h8;
    tick(9);
    wr(2'd3, 32'h4);
    rd(2'd0, 32'h8, "collide_data");
    rd(2'd3, 32'h4, "collide_cap");
    chk_irq(1'b0, "collide_irq_masked");
    wr(2'd2, 32'h4);
    chk_irq(1'b1, "mask_enables_irq");
    wr(2'd2, 32'h0);
    chk_irq(1'b0, "mask_disables_irq");

    // release of bit0 leaves EDGECAP untouched
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "cap_all_cleared");
    in_port = 4'h9;
    tick(12);
    rd(2'd0, 32'h9, "release2_data");
    rd(2'd3, 32'h0, "release2_no_cap");

    // reset in the middle of a debounce
    wr(2'd2, 32'hF);
    in_port = 4'h8;
    tick(10);
    rd(2'd3, 32'h1, "pre_reset_cap");
    chk_irq(1'b1, "pre_reset_irq");
    in_port = 4'h0;
    tick(6);
    reset_n = 1'b0;
    chk_irq(1'b0, "reset_irq_async");
    rd(2'd0, 32'hF, "reset_data");
    rd(2'd2, 32'h0, "reset_mask");
    rd(2'd3, 32'h0, "reset_cap");
    tick(2);
    reset_n = 1'b1;
    tick(9);
    rd(2'd0, 32'hF, "held_data_early");
    rd(2'd3, 32'h0, "held_cap_early");
    tick(1);
    rd(2'd0, 32'h0, "held_data");
    rd(2'd3, 32'hF, "held_cap");
    chk_irq(1'b0, "held_irq_masked");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
